fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that sits directly upstream of ins_mem. Owns the fetch PC,
//  drives the byte address into ins_mem and captures the registered instruction it
//  returns one edge later. Buffers fetched words in a small FIFO and presents
//  {pc, instruction} to decode over a valid/ready handshake.
//  Handles redirects (branch/jump) from execute by squashing in-flight and buffered fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded on reset; bits [1:0] must be 0
//  FIFO_DEPTH  2              fetch buffer entries; power of two, >= 2
// PORTS
//  del_clk         in   1   clock; all state updates on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_addr       out  32  byte address to ins_mem; equals fetch_pc (combinational)
//  imem_rdata      in   32  ins_mem instruction; holds data for the address of the previous cycle
//  redirect_valid  in   1   execute requests a PC change this cycle
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced to 0)
//  if_valid        out  1   FIFO head holds a valid instruction
//  if_ready        in   1   decode accepts the head this cycle
//  if_pc           out  32  PC of the head instruction
//  if_instr        out  32  head instruction word
// BEHAVIOUR
//  Reset (async assert, sync release): fetch_pc=RESET_PC, inflight_vld=0, FIFO empty.
//   Outputs: if_valid=0, if_pc=0, if_instr=0, imem_addr=RESET_PC.
//  State: fetch_pc[31:0], inflight_vld, inflight_pc[31:0], FIFO with rd/wr ptrs and a
//   count (0..FIFO_DEPTH).
//  pop  = if_valid & if_ready.
//  issue = !redirect_valid & (count + inflight_vld - pop < FIFO_DEPTH).
//   This is a credit check: a returning word can never overflow the FIFO.
//  On an issue edge:
//   - inflight_vld<=1
//   - inflight_pc<=fetch_pc
//   - fetch_pc<=fetch_pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0)
//  On a no-issue edge: inflight_vld<=0 and fetch_pc holds.
//  Push: on an edge where inflight_vld=1 and no redirect, write {inflight_pc, imem_rdata}.
//  Push and pop on the same edge are legal. Count is unchanged when both occur, and the
//   pop may come from a FIFO that was full at the start of the cycle.
//  Latency: the address issued at edge N is pushed at edge N+1 and is visible as
//   if_valid after N+1.
//   - First instruction: if_valid rises after the 2nd posedge following reset release.
//   - Throughput: 1 instruction/cycle sustained while if_ready=1.
//  Redirect (priority over everything) on an edge with redirect_valid=1:
//   - FIFO flushed (count=0)
//   - inflight_vld<=0 (squashes the word returning next cycle)
//   - no push, no issue; a same-cycle pop is still counted as accepted by decode
//   - fetch_pc<={redirect_pc[31:2],2'b00}
//   The target is issued on the next edge, so if_valid returns 2 edges after the redirect edge.
//  Backpressure: while if_ready=0 with FIFO full:
//   - issue stops and fetch_pc holds
//   - head {if_pc, if_instr} stays stable
//   - no word is lost or duplicated
//  Ordering: if_pc is strictly sequential (+4) between redirects.
//  if_pc/if_instr when if_valid=0: hold the last head value (0 after reset); decode ignores them.
//  Reset asserted mid-stream: all state returns to its reset values immediately (async);
//   no partial push survives.
// TESTING
//  1. Reset, if_ready=1, mem[i]=i+0x100 -> if_valid rises after edge 2; (pc,instr)=(0,0x100),(4,0x101),(8,0x102)... one per cycle.
//  2. Stream, then if_ready=0 for 6 cycles -> FIFO holds FIFO_DEPTH entries, imem_addr frozen;
//     release -> no gap, no duplicate, pcs contiguous.
//  3. redirect_valid=1 with redirect_pc=0x40 while FIFO full -> if_valid=0 next cycle;
//     first valid pc=0x40 two edges later; no stale pc (e.g. 0x8) ever seen.
//  4. Redirect with if_ready=1 and a valid head on the same edge -> head consumed once; next valid pc=target.
//  5. RESET_PC=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//     redirect_pc=0x13 -> fetch at 0x10.
//  6. Assert rst_n=0 mid-stream between edges -> if_valid=0 immediately;
//     after release the stream restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Generic credit-managed FIFO: stores words written by the producer and presents the oldest word.
// Latency: a word written on edge N is visible at rd_dat after edge N; flush empties it on the same edge.
// Backpressure: no write-side ready; the producer must hold credits so it never writes past DEPTH unless a read retires a slot that same edge.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_rd;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_rd  = rd_vld & rd_rdy;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_vld) - CW'(do_rd);
        end
    end

    // Storage is not reset: a slot is only observed once count says it was written.
    always_ff @(posedge clk) begin
        if (wr_vld && !flush) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Instruction fetch: owns the fetch PC, drives ins_mem, buffers returned words and hands {pc, instr} to decode.
// Latency: an address issued on edge N is pushed on edge N+1 (if_valid two edges after reset release or a redirect).
// Backpressure: issue only when the FIFO has a free credit for the returning word; with if_ready=0 and a full FIFO the PC and head hold.
// Ports: del_clk/rst_n clock and async active-low reset; imem_addr/imem_rdata ins_mem address and registered data;
//        redirect_valid/redirect_pc PC change from execute; if_valid/if_ready/if_pc/if_instr decode handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        del_clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_word_t;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight_vld;
    fetch_word_t   push_dat;
    fetch_word_t   head_dat;
    fetch_word_t   hold_dat;
    logic          head_vld;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW:0]   occ_next;

    assign imem_addr = fetch_pc;
    assign pop       = head_vld & if_ready;
    assign push      = inflight_vld & ~redirect_valid;
    assign push_dat  = {inflight_pc, imem_rdata};

    // Occupancy after this edge if nothing new were issued: buffered words plus the
    // word already in flight, minus what decode takes now. Issue only if a slot remains.
    assign occ_next = (CW+1)'(count) + (CW+1)'(inflight_vld) - (CW+1)'(pop);
    assign issue    = ~redirect_valid & (occ_next < (CW+1)'(FIFO_DEPTH));

    fetch_fifo #(
        .W     ($bits(fetch_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (del_clk),
        .rst_n  (rst_n),
        .flush  (redirect_valid),
        .wr_vld (push),
        .wr_dat (push_dat),
        .rd_rdy (if_ready),
        .rd_vld (head_vld),
        .rd_dat (head_dat),
        .count  (count)
    );

    always_ff @(posedge del_clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            inflight_vld <= 1'b0;
            inflight_pc  <= '0;
        end else if (redirect_valid) begin
            // Squash the word returning next cycle; the target issues on the following edge.
            fetch_pc     <= redirect_pc & 32'hFFFF_FFFC;
            inflight_vld <= 1'b0;
        end else begin
            inflight_vld <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

    // Decode sees the last presented head while the FIFO is empty (zero after reset).
    always_ff @(posedge del_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_dat <= '0;
        end else if (head_vld) begin
            hold_dat <= head_dat;
        end
    end

    assign if_valid          = head_vld;
    assign {if_pc, if_instr} = head_vld ? head_dat : hold_dat;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic        del_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2 = 32'h0;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_instr2;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    always #5 del_clk = ~del_clk;

    fetch_unit dut (
        .del_clk        (del_clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
        .del_clk        (del_clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (if_valid2),
        .if_ready       (1'b1),
        .if_pc          (if_pc2),
        .if_instr       (if_instr2)
    );

    // ins_mem content: word index + 0x100.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'h100;
    endfunction

    // Registered instruction memory: data for the address of the previous cycle.
    always @(posedge del_clk) begin
        imem_rdata  <= mem_word(imem_addr);
        imem_rdata2 <= mem_word(imem_addr2);
    end

    int checks = 0;
    int errors = 0;
    int hs_main = 0;
    int hs_wrap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the decode stream is the sequential program from the last start PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] gen_pc = 32'h0;

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc;
        refill();
    endtask

    // Main monitor: every presented head must be the next expected word.
    always @(negedge del_clk) begin
        if (rst_n === 1'b1 && if_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_head: got pc %h, expected no output", if_pc);
            end else begin
                check("head_pc", if_pc, exp_q[0].pc);
                check("head_instr", if_instr, exp_q[0].instr);
                if (if_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    hs_main++;
                end
            end
        end
    end

    // Wrap instance: always ready, never redirected, stream from WRAP_PC.
    logic [31:0] exp2_pc = WRAP_PC;
    always @(negedge del_clk) begin
        if (rst_n !== 1'b1) begin
            exp2_pc = WRAP_PC;
        end else if (if_valid2 === 1'b1) begin
            check("wrap_pc", if_pc2, exp2_pc);
            check("wrap_instr", if_instr2, mem_word(exp2_pc));
            exp2_pc = exp2_pc + 32'd4;
            hs_wrap++;
        end
    end

    // Drive one cycle of inputs (called at posedge+1), wait for the edge, update the model.
    task automatic tick(input logic rdy, input logic redir, input logic [31:0] tgt);
        if_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        @(posedge del_clk);
        #1;
        redirect_valid = 1'b0;
        if (redir) restart(tgt & 32'hFFFF_FFFC);
        else refill();
    endtask

    task automatic start_checks(input string tag);
        tick(1'b1, 1'b0, 32'h0);
        check({tag, "_valid_edge1"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_addr_edge1"}, imem_addr, 32'h4);
        tick(1'b1, 1'b0, 32'h0);
        check({tag, "_valid_edge2"}, {31'b0, if_valid}, 32'd1);
    endtask

    logic [31:0] saved_addr;

    initial begin
        #1 rst_n = 1'b0;
        restart(32'h0);
        repeat (2) @(posedge del_clk);
        #1;
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_addr_wrap", imem_addr2, WRAP_PC);
        check("rst_valid_wrap", {31'b0, if_valid2}, 32'd0);
        rst_n = 1'b1;

        // First instruction latency and sustained throughput.
        start_checks("boot");
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            check("stream_valid", {31'b0, if_valid}, 32'd1);
        end

        // Backpressure: FIFO fills, PC freezes, release without gap.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (i == 2) saved_addr = imem_addr;
            if (i > 2) begin
                check("bp_addr_frozen", imem_addr, saved_addr);
                check("bp_valid", {31'b0, if_valid}, 32'd1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            check("release_valid", {31'b0, if_valid}, 32'd1);
        end

        // Redirect while full.
        repeat (3) tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h40);
        check("redir_full_valid0", {31'b0, if_valid}, 32'd0);
        tick(1'b1, 1'b0, 32'h0);
        check("redir_full_valid1", {31'b0, if_valid}, 32'd0);
        tick(1'b1, 1'b0, 32'h0);
        check("redir_full_valid2", {31'b0, if_valid}, 32'd1);
        check("redir_full_pc", if_pc, 32'h40);

        // Redirect on the same edge as a consumed head.
        repeat (3) tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h200);
        repeat (2) tick(1'b1, 1'b0, 32'h0);
        check("redir_pop_pc", if_pc, 32'h200);

        // Unaligned target and wrap through the top of the address space.
        tick(1'b1, 1'b1, 32'h13);
        repeat (2) tick(1'b1, 1'b0, 32'h0);
        check("redir_align_pc", if_pc, 32'h10);
        tick(1'b1, 1'b1, 32'hFFFF_FFF9);
        repeat (6) tick(1'b1, 1'b0, 32'h0);

        // Reset between edges mid-stream.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, if_valid}, 32'd0);
        check("midrst_pc", if_pc, 32'h0);
        check("midrst_addr", imem_addr, 32'h0);
        restart(32'h0);
        @(posedge del_clk);
        #1;
        rst_n = 1'b1;
        start_checks("rerun");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        rdy;
            logic        redir;
            logic [31:0] tgt;
            rdy   = ($urandom_range(0, 99) < 65);
            redir = ($urandom_range(0, 99) < 4);
            tgt   = $urandom();
            tick(rdy, redir, tgt);
        end
        repeat (4) tick(1'b1, 1'b0, 32'h0);

        check("hs_main_progress", {31'b0, (hs_main > 1000)}, 32'd1);
        check("hs_wrap_progress", {31'b0, (hs_wrap > 1000)}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
